// File: rtl/sys_defs_pkg.sv
// Shared type definitions for the issue stage and functional units.
//   FUM     : functional-unit class carried by each RS entry
//   FU_FUNC : decoded operation within a functional unit
//   idx_w   : index width for an N-entry structure (never below 1)
package sys_defs;

  typedef enum logic [1:0] {
    FU_ALU,
    FU_MULT,
    FU_MEM,
    FU_BRANCH
  } FUM;

  typedef enum logic [3:0] {
    FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_SLL, FUNC_SRL,
    FUNC_MUL, FUNC_LD, FUNC_ST, FUNC_BEQ, FUNC_BNE
  } FU_FUNC;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin multi-grant picker.
//   req       : request vector (WIDTH, power of two)
//   ptr       : highest-priority index this cycle
//   gnt_valid : grant valids, packed from bit 0
//   gnt_idx   : granted indices; slot k holds the k-th request found
//   next_ptr  : last granted index + 1 (wraps), or ptr when nothing granted
module rr_picker
  import sys_defs::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_GRANT = 1,
  localparam int unsigned IW       = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0]                  req,
  input  logic [IW-1:0]                     ptr,
  output logic [NUM_GRANT-1:0]              gnt_valid,
  output logic [NUM_GRANT-1:0][IW-1:0]      gnt_idx,
  output logic [IW-1:0]                     next_ptr
);

  logic [IW-1:0] idx;
  int unsigned   found;

  // WIDTH is a power of two, so ptr + offset wraps naturally in IW bits.
  always_comb begin
    gnt_valid = '0;
    gnt_idx   = '0;
    next_ptr  = ptr;
    idx       = '0;
    found     = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      idx = ptr + IW'(i);
      if (req[idx]) begin
        for (int unsigned k = 0; k < NUM_GRANT; k++) begin
          if (found == k) begin
            gnt_valid[k] = 1'b1;
            gnt_idx[k]   = idx;
            next_ptr     = idx + IW'(1);
          end
        end
        if (found < NUM_GRANT) found++;
      end
    end
  end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Issue-stage scheduler: picks ready RS entries per FU class with round-robin
// priority and sequences the iterative multiplier.
//   clock, reset_n        : clock, synchronous active-low reset
//   rs_ready, rs_fu       : per-entry ready flag and FU class
//   stall                 : blocks all grants (mult counter keeps running)
//   squash                : aborts the multiply in progress
//   mem_ready             : memory unit can accept an op
//   issue_mask            : one-hot OR of every granted entry
//   alu_valid/alu_idx     : per-ALU grant
//   mult/mem/br_valid,idx : single-instance class grants
//   mult_busy, mult_done  : multiplier occupancy / result pulse
module fu_issue_scheduler
  import sys_defs::*;
#(
  parameter int unsigned RS_SIZE     = 8,
  parameter int unsigned NUM_ALU     = 2,
  parameter int unsigned MULT_CYCLES = 4,
  localparam int unsigned IDX_W      = idx_w(RS_SIZE)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [RS_SIZE-1:0]              rs_ready,
  input  FUM   [RS_SIZE-1:0]              rs_fu,
  input  logic                            stall,
  input  logic                            squash,
  input  logic                            mem_ready,
  output logic [RS_SIZE-1:0]              issue_mask,
  output logic [NUM_ALU-1:0]              alu_valid,
  output logic [NUM_ALU-1:0][IDX_W-1:0]   alu_idx,
  output logic                            mult_valid,
  output logic                            mem_valid,
  output logic                            br_valid,
  output logic [IDX_W-1:0]                mult_idx,
  output logic [IDX_W-1:0]                mem_idx,
  output logic [IDX_W-1:0]                br_idx,
  output logic                            mult_busy,
  output logic                            mult_done
);

  localparam int unsigned CW = idx_w(MULT_CYCLES);

  typedef enum logic {M_IDLE, M_BUSY} mult_state_e;

  mult_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  logic [IDX_W-1:0] ptr_alu, ptr_mult, ptr_mem, ptr_br;
  logic [IDX_W-1:0] ptr_alu_nxt, ptr_mult_nxt, ptr_mem_nxt, ptr_br_nxt;

  logic               grant_en, mult_open;
  logic [RS_SIZE-1:0] req_alu, req_mult, req_mem, req_br;

  // Requests are masked by class and by every enable, so the pickers'
  // next_ptr already equals ptr whenever a class is blocked.
  always_comb begin
    grant_en  = reset_n && !stall;
    mult_open = grant_en && !squash && (state_q == M_IDLE || count_q == '0);
    req_alu   = '0;
    req_mult  = '0;
    req_mem   = '0;
    req_br    = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      req_alu[i]  = grant_en  && rs_ready[i] && (rs_fu[i] == FU_ALU);
      req_mult[i] = mult_open && rs_ready[i] && (rs_fu[i] == FU_MULT);
      req_mem[i]  = grant_en  && mem_ready && rs_ready[i] && (rs_fu[i] == FU_MEM);
      req_br[i]   = grant_en  && rs_ready[i] && (rs_fu[i] == FU_BRANCH);
    end
  end

  rr_picker #(.WIDTH(RS_SIZE), .NUM_GRANT(NUM_ALU)) u_pick_alu (
    .req(req_alu), .ptr(ptr_alu), .gnt_valid(alu_valid), .gnt_idx(alu_idx),
    .next_ptr(ptr_alu_nxt));

  rr_picker #(.WIDTH(RS_SIZE), .NUM_GRANT(1)) u_pick_mult (
    .req(req_mult), .ptr(ptr_mult), .gnt_valid(mult_valid), .gnt_idx(mult_idx),
    .next_ptr(ptr_mult_nxt));

  rr_picker #(.WIDTH(RS_SIZE), .NUM_GRANT(1)) u_pick_mem (
    .req(req_mem), .ptr(ptr_mem), .gnt_valid(mem_valid), .gnt_idx(mem_idx),
    .next_ptr(ptr_mem_nxt));

  rr_picker #(.WIDTH(RS_SIZE), .NUM_GRANT(1)) u_pick_br (
    .req(req_br), .ptr(ptr_br), .gnt_valid(br_valid), .gnt_idx(br_idx),
    .next_ptr(ptr_br_nxt));

  always_comb begin
    issue_mask = '0;
    for (int unsigned k = 0; k < NUM_ALU; k++)
      if (alu_valid[k]) issue_mask[alu_idx[k]] = 1'b1;
    if (mult_valid) issue_mask[mult_idx] = 1'b1;
    if (mem_valid)  issue_mask[mem_idx]  = 1'b1;
    if (br_valid)   issue_mask[br_idx]   = 1'b1;
  end

  // count is the number of BUSY cycles left before the done cycle, so the
  // load value is MULT_CYCLES-2: done lands MULT_CYCLES-1 cycles after grant.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      M_IDLE: begin
        if (mult_valid) begin
          state_d = M_BUSY;
          count_d = CW'(MULT_CYCLES - 2);
        end
      end
      M_BUSY: begin
        if (count_q == '0) begin
          if (mult_valid) count_d = CW'(MULT_CYCLES - 2);
          else            state_d = M_IDLE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: state_d = M_IDLE;
    endcase
    if (squash) begin
      state_d = M_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= M_IDLE;
      count_q  <= '0;
      ptr_alu  <= '0;
      ptr_mult <= '0;
      ptr_mem  <= '0;
      ptr_br   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ptr_alu  <= ptr_alu_nxt;
      ptr_mult <= ptr_mult_nxt;
      ptr_mem  <= ptr_mem_nxt;
      ptr_br   <= ptr_br_nxt;
    end
  end

  assign mult_busy = reset_n && (state_q == M_BUSY);
  assign mult_done = reset_n && (state_q == M_BUSY) && (count_q == '0);

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Self-checking bench for fu_issue_scheduler with a behavioural model.
module tb_fu_issue_scheduler;
  import sys_defs::*;

  localparam int RS = 8;
  localparam int NA = 2;
  localparam int MC = 4;

  typedef FUM [RS-1:0] fu_vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n, stall, squash, mem_ready;
  logic [RS-1:0]     rs_ready;
  fu_vec_t           rs_fu;
  logic [RS-1:0]     issue_mask;
  logic [NA-1:0]     alu_valid;
  logic [NA-1:0][2:0] alu_idx;
  logic              mult_valid, mem_valid, br_valid;
  logic [2:0]        mult_idx, mem_idx, br_idx;
  logic              mult_busy, mult_done;

  fu_issue_scheduler #(.RS_SIZE(RS), .NUM_ALU(NA), .MULT_CYCLES(MC)) dut (
    .clock(clock), .reset_n(reset_n), .rs_ready(rs_ready), .rs_fu(rs_fu),
    .stall(stall), .squash(squash), .mem_ready(mem_ready),
    .issue_mask(issue_mask), .alu_valid(alu_valid), .alu_idx(alu_idx),
    .mult_valid(mult_valid), .mem_valid(mem_valid), .br_valid(br_valid),
    .mult_idx(mult_idx), .mem_idx(mem_idx), .br_idx(br_idx),
    .mult_busy(mult_busy), .mult_done(mult_done));

  int total = 0;
  int bad   = 0;

  // Model state: round-robin pointers and remaining multiplier cycles
  // (busy_left==1 means this is the done cycle, 0 means idle).
  int p_alu, p_mult, p_mem, p_br, busy_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick_one(input int p, input logic [RS-1:0] r,
                                  input fu_vec_t f, input FUM c, input bit en);
    for (int i = 0; i < RS; i++) begin
      int j;
      j = (p + i) % RS;
      if (en && r[j] && f[j] == c) return j;
    end
    return -1;
  endfunction

  function automatic fu_vec_t all_fu(input FUM c);
    fu_vec_t v;
    for (int i = 0; i < RS; i++) v[i] = c;
    return v;
  endfunction

  task automatic cycle(input bit rn, input logic [RS-1:0] rdy, input fu_vec_t fu,
                       input bit st, input bit sq, input bit mr);
    bit ge, men;
    logic [RS-1:0] em;
    int cnt, av, np_alu, jm, jme, jb;
    int ai [NA];
    @(negedge clock);
    reset_n = rn; rs_ready = rdy; rs_fu = fu; stall = st; squash = sq; mem_ready = mr;
    #2;
    ge = rn && !st;
    em = '0; cnt = 0; av = 0; np_alu = p_alu;
    for (int k = 0; k < NA; k++) ai[k] = 0;
    for (int i = 0; i < RS; i++) begin
      int j;
      j = (p_alu + i) % RS;
      if (ge && rdy[j] && fu[j] == FU_ALU && cnt < NA) begin
        ai[cnt] = j; av |= (1 << cnt); cnt++; em[j] = 1'b1; np_alu = (j + 1) % RS;
      end
    end
    men = ge && !sq && busy_left <= 1;
    jm  = pick_one(p_mult, rdy, fu, FU_MULT, men);
    jme = pick_one(p_mem, rdy, fu, FU_MEM, ge && mr);
    jb  = pick_one(p_br, rdy, fu, FU_BRANCH, ge);
    if (jm >= 0)  em[jm]  = 1'b1;
    if (jme >= 0) em[jme] = 1'b1;
    if (jb >= 0)  em[jb]  = 1'b1;

    chk("issue_mask", issue_mask, em);
    chk("alu_valid", alu_valid, av);
    for (int k = 0; k < NA; k++)
      if (av[k] || !ge) chk("alu_idx", alu_idx[k], ai[k]);
    chk("mult_valid", mult_valid, jm >= 0);
    if (jm >= 0 || !ge) chk("mult_idx", mult_idx, (jm >= 0) ? jm : 0);
    chk("mem_valid", mem_valid, jme >= 0);
    if (jme >= 0 || !ge) chk("mem_idx", mem_idx, (jme >= 0) ? jme : 0);
    chk("br_valid", br_valid, jb >= 0);
    if (jb >= 0 || !ge) chk("br_idx", br_idx, (jb >= 0) ? jb : 0);
    chk("mult_busy", mult_busy, rn && busy_left > 0);
    chk("mult_done", mult_done, rn && busy_left == 1);

    if (!rn) begin
      p_alu = 0; p_mult = 0; p_mem = 0; p_br = 0; busy_left = 0;
    end else begin
      p_alu = np_alu;
      if (jm >= 0)  p_mult = (jm + 1) % RS;
      if (jme >= 0) p_mem  = (jme + 1) % RS;
      if (jb >= 0)  p_br   = (jb + 1) % RS;
      if (sq)            busy_left = 0;
      else if (jm >= 0)  busy_left = MC - 1;
      else if (busy_left > 0) busy_left--;
    end
  endtask

  task automatic do_reset();
    cycle(0, '0, all_fu(FU_ALU), 0, 0, 0);
    cycle(0, '0, all_fu(FU_ALU), 0, 0, 0);
  endtask

  initial begin
    fu_vec_t f;
    reset_n = 0; rs_ready = '0; rs_fu = all_fu(FU_ALU);
    stall = 0; squash = 0; mem_ready = 0;
    p_alu = 0; p_mult = 0; p_mem = 0; p_br = 0; busy_left = 0;

    // 1: ALU round robin
    do_reset();
    chk("rst_mask", issue_mask, 8'h00);
    chk("rst_busy", mult_busy, 0);
    cycle(1, 8'hFF, all_fu(FU_ALU), 0, 0, 1);
    chk("t1_alu0", alu_idx[0], 0);
    chk("t1_alu1", alu_idx[1], 1);
    chk("t1_mask", issue_mask, 8'h03);
    cycle(1, 8'hFC, all_fu(FU_ALU), 0, 0, 1);
    chk("t1b_alu0", alu_idx[0], 2);
    chk("t1b_alu1", alu_idx[1], 3);
    chk("t1b_mask", issue_mask, 8'h0C);

    // 2: back-to-back multiplies
    do_reset();
    f = all_fu(FU_ALU); f[5] = FU_MULT; f[6] = FU_MULT;
    cycle(1, 8'h20, f, 0, 0, 0);
    chk("t2_grant0", {mult_valid, mult_idx}, {1'b1, 3'd5});
    for (int t = 1; t <= 6; t++) begin
      cycle(1, (t <= 3) ? 8'h40 : 8'h00, f, 0, 0, 0);
      if (t == 1) chk("t2_busy1", {mult_busy, mult_done, mult_valid}, 3'b100);
      if (t == 3) chk("t2_done3", {mult_busy, mult_done, mult_valid, mult_idx}, {3'b111, 3'd6});
      if (t == 6) chk("t2_done6", mult_done, 1);
    end

    // 3: squash mid-multiply
    do_reset();
    f = all_fu(FU_ALU); f[2] = FU_MULT;
    cycle(1, 8'h04, f, 0, 0, 0);
    cycle(1, 8'h00, f, 0, 1, 0);
    chk("t3_sq_done", mult_done, 0);
    cycle(1, 8'h04, f, 0, 0, 0);
    chk("t3_regrant", {mult_busy, mult_valid, mult_idx}, {2'b01, 3'd2});
    for (int t = 0; t < 4; t++) cycle(1, 8'h00, f, 0, 0, 0);

    // 4: memory handshake
    do_reset();
    f = all_fu(FU_ALU); f[2] = FU_MEM; f[3] = FU_MEM;
    for (int t = 0; t < 3; t++) begin
      cycle(1, 8'h08, f, 0, 0, 0);
      chk("t4_hold", mem_valid, 0);
    end
    cycle(1, 8'h08, f, 0, 0, 1);
    chk("t4_grant", {mem_valid, mem_idx}, {1'b1, 3'd3});
    cycle(1, 8'h0C, f, 0, 0, 1);
    chk("t4_wrap", {mem_valid, mem_idx}, {1'b1, 3'd2});

    // 5: branch wrap-around with a stall
    do_reset();
    f = all_fu(FU_ALU); f[0] = FU_BRANCH; f[6] = FU_BRANCH; f[7] = FU_BRANCH;
    cycle(1, 8'h40, f, 0, 0, 0);
    cycle(1, 8'h81, f, 0, 0, 0);
    chk("t5_br7", {br_valid, br_idx}, {1'b1, 3'd7});
    cycle(1, 8'h01, f, 1, 0, 0);
    chk("t5_stall", {br_valid, issue_mask}, 9'd0);
    cycle(1, 8'h01, f, 0, 0, 0);
    chk("t5_br0", {br_valid, br_idx}, {1'b1, 3'd0});

    // 6: reset during BUSY
    do_reset();
    for (int i = 0; i < RS; i++) f[i] = FUM'(i % 4);
    cycle(1, 8'h02, f, 0, 0, 1);
    cycle(0, 8'hFF, f, 0, 0, 1);
    chk("t6_rst", {issue_mask, alu_valid, mult_valid, mem_valid, br_valid,
                   mult_busy, mult_done}, '0);
    cycle(1, 8'hFF, f, 0, 0, 1);
    chk("t6_alu", {alu_idx[0], alu_idx[1]}, {3'd0, 3'd4});
    chk("t6_mult", {mult_busy, mult_valid, mult_idx}, {2'b01, 3'd1});
    chk("t6_mask", issue_mask, 8'h1F);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < RS; i++) f[i] = FUM'($urandom_range(3));
      cycle($urandom_range(63) != 0, RS'($urandom), f,
            $urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
